// File: rtl/serializer_piso_if.sv
`default_nettype none
// ============================================================================
// Module      : serializer_piso_if
// Description : Parallel-load / serial-out handshake bundle. The master side
//               supplies the word and the load/shift/clear controls; the
//               slave side (the serializer) returns the serial bit, the
//               qualifiers and the consumed-bit count.
// Revision    : 1.0 - initial release
// ============================================================================
interface serializer_piso_if #(
    parameter int WORD_LENGTH = 8
);
    localparam int CNT_W = $clog2(WORD_LENGTH + 1);

    logic [WORD_LENGTH-1:0] data_in;
    logic                   load;
    logic                   shift;
    logic                   clear;
    logic                   data_out;
    logic                   valid;
    logic                   done;
    logic [CNT_W-1:0]       bit_count;

    modport master (
        output data_in, load, shift, clear,
        input  data_out, valid, done, bit_count
    );

    modport slave (
        input  data_in, load, shift, clear,
        output data_out, valid, done, bit_count
    );
endinterface
`default_nettype wire

// File: rtl/serializer_piso.sv
`default_nettype none
// ============================================================================
// Module      : serializer_piso
// Description : Parallel-in / serial-out shifter with an IDLE/SHIFT/DONE
//               FSM. Captures a word on load, emits one bit per shift
//               (LSB or MSB first), pulses done after the last bit and
//               allows a back-to-back reload from DONE.
// Revision    : 1.0 - initial release
// ============================================================================
module serializer_piso #(
    parameter int WORD_LENGTH = 8,
    parameter bit MSB_FIRST   = 1'b0
) (
    input  logic                clk,
    input  logic                reset,
    serializer_piso_if.slave    bus
);
    localparam int CNT_W = $clog2(WORD_LENGTH + 1);
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(WORD_LENGTH - 1);
    localparam logic [CNT_W-1:0] c_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [WORD_LENGTH-1:0] r_shreg;
    logic [WORD_LENGTH-1:0] w_shreg_nxt;
    logic [WORD_LENGTH-1:0] w_shifted;
    logic [CNT_W-1:0]       r_bit_count;
    logic [CNT_W-1:0]       w_bit_count_nxt;
    logic                   w_out_bit;

    // Output end of the register and its zero-filled shifted image
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_out_bit = r_shreg[WORD_LENGTH-1];
            assign w_shifted = {r_shreg[WORD_LENGTH-2:0], 1'b0};
        end else begin : g_lsb_first
            assign w_out_bit = r_shreg[0];
            assign w_shifted = {1'b0, r_shreg[WORD_LENGTH-1:1]};
        end
    endgenerate

    // State, shift register and bit counter; reset discards any word in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_shreg     <= '0;
            r_bit_count <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_shreg     <= w_shreg_nxt;
            r_bit_count <= w_bit_count_nxt;
        end
    end

    // Next-state logic; clear overrides everything and never produces done
    always_comb begin
        w_state_nxt     = r_state;
        w_shreg_nxt     = r_shreg;
        w_bit_count_nxt = r_bit_count;
        if (bus.clear) begin
            w_state_nxt     = S_IDLE;
            w_shreg_nxt     = '0;
            w_bit_count_nxt = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // A shift arriving with load only captures; no bit is consumed
                    if (bus.load) begin
                        w_shreg_nxt     = bus.data_in;
                        w_bit_count_nxt = '0;
                        w_state_nxt     = S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    // load is ignored here so the word in flight is protected
                    if (bus.shift) begin
                        w_shreg_nxt     = w_shifted;
                        w_bit_count_nxt = r_bit_count + c_ONE;
                        if (r_bit_count == c_LAST) begin
                            w_state_nxt = S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    // Reload straight into SHIFT for gapless back-to-back words
                    if (bus.load) begin
                        w_shreg_nxt     = bus.data_in;
                        w_bit_count_nxt = '0;
                        w_state_nxt     = S_SHIFT;
                    end else begin
                        w_state_nxt     = S_IDLE;
                    end
                end
                default: begin
                    w_state_nxt     = S_IDLE;
                    w_shreg_nxt     = '0;
                    w_bit_count_nxt = '0;
                end
            endcase
        end
    end

    // Outputs are pure decodes of registered state; data_out is forced low outside SHIFT
    always_comb begin
        bus.valid     = (r_state == S_SHIFT);
        bus.done      = (r_state == S_DONE);
        bus.data_out  = (r_state == S_SHIFT) ? w_out_bit : 1'b0;
        bus.bit_count = r_bit_count;
    end
endmodule
`default_nettype wire
